// File: rtl/coll_pair_sched.sv
// Pair scheduler for coll_det: walks every i<j pair of the object table, holds
// the shared datapath's in_rdy for DET_LAT cycles per pair and streams hits.
module coll_pair_sched #(
    parameter int N_OBJ   = 8,
    parameter int W       = 16,
    parameter int AW      = 3,
    parameter int CW      = 8,
    parameter int DET_LAT = 10
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_x,
    input  logic [W-1:0]  wr_y,
    input  logic [W-1:0]  wr_vx,
    input  logic [W-1:0]  wr_vy,
    input  logic [W-1:0]  r2,
    input  logic [AW:0]   num_obj,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          hit_valid,
    output logic [AW-1:0] hit_i,
    output logic [AW-1:0] hit_j,
    output logic [CW-1:0] hit_count,
    output logic          wr_err,
    output logic [W-1:0]  det_x1,
    output logic [W-1:0]  det_y1,
    output logic [W-1:0]  det_x2,
    output logic [W-1:0]  det_y2,
    output logic [W-1:0]  det_vx1,
    output logic [W-1:0]  det_vy1,
    output logic [W-1:0]  det_vx2,
    output logic [W-1:0]  det_vy2,
    output logic [W-1:0]  det_r2,
    output logic          det_in_rdy,
    input  logic          det_trial
);
    localparam int LW = $clog2(DET_LAT + 1);

    typedef enum logic [2:0] {IDLE, SETUP, RUN, SAMPLE, FIN} state_t;
    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] vx;
        logic [W-1:0] vy;
    } obj_t;

    state_t        r_state;
    obj_t          r_tab [N_OBJ];
    obj_t          r_op1, r_op2;
    logic [W-1:0]  r_r2, r_det_r2;
    logic [AW:0]   r_n, r_i, r_j;
    logic [LW-1:0] r_cnt;
    logic          r_busy, r_done, r_hit_valid, r_wr_err, r_in_rdy;
    logic [AW-1:0] r_hit_i, r_hit_j;
    logic [CW-1:0] r_hit_count;

    logic [AW:0]   w_n_lat, w_j_inc, w_i_nx, w_j_nx;
    logic          w_last;

    assign w_n_lat = (num_obj > (AW+1)'(N_OBJ)) ? (AW+1)'(N_OBJ) : num_obj;
    assign w_j_inc = r_j + 1'b1;

    // Indices are AW+1 bits so j reaching num_obj==N_OBJ does not wrap.
    always_comb begin
        w_i_nx = r_i;
        w_j_nx = w_j_inc;
        if (w_j_inc >= r_n) begin
            w_i_nx = r_i + 1'b1;
            w_j_nx = r_i + (AW+1)'(2);
        end
    end
    assign w_last = (w_i_nx >= (r_n - 1'b1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            for (int unsigned k = 0; k < N_OBJ; k++) r_tab[k] <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_r2        <= '0;
            r_det_r2    <= '0;
            r_n         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit_valid <= 1'b0;
            r_wr_err    <= 1'b0;
            r_in_rdy    <= 1'b0;
            r_hit_i     <= '0;
            r_hit_j     <= '0;
            r_hit_count <= '0;
        end else begin
            r_done      <= 1'b0;
            r_hit_valid <= 1'b0;
            r_wr_err    <= 1'b0;
            if (wr_en) begin
                if (r_state == IDLE) r_tab[wr_addr] <= {wr_x, wr_y, wr_vx, wr_vy};
                else                 r_wr_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_r2        <= r2;
                        r_n         <= w_n_lat;
                        r_hit_count <= '0;
                        r_i         <= '0;
                        r_j         <= (AW+1)'(1);
                        r_busy      <= 1'b1;
                        r_state     <= (w_n_lat < (AW+1)'(2)) ? FIN : SETUP;
                    end
                end
                SETUP: begin
                    r_op1    <= r_tab[r_i[AW-1:0]];
                    r_op2    <= r_tab[r_j[AW-1:0]];
                    r_det_r2 <= r_r2;
                    r_cnt    <= '0;
                    r_in_rdy <= 1'b1;
                    r_state  <= RUN;
                end
                RUN: begin
                    if (r_cnt == LW'(DET_LAT - 1)) begin
                        r_in_rdy <= 1'b0;
                        r_state  <= SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (det_trial) begin
                        r_hit_valid <= 1'b1;
                        r_hit_i     <= r_i[AW-1:0];
                        r_hit_j     <= r_j[AW-1:0];
                        if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
                    end
                    r_i     <= w_i_nx;
                    r_j     <= w_j_nx;
                    r_state <= w_last ? FIN : SETUP;
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign hit_valid  = r_hit_valid;
    assign hit_i      = r_hit_i;
    assign hit_j      = r_hit_j;
    assign hit_count  = r_hit_count;
    assign wr_err     = r_wr_err;
    assign det_in_rdy = r_in_rdy;
    assign det_x1     = r_op1.x;
    assign det_y1     = r_op1.y;
    assign det_vx1    = r_op1.vx;
    assign det_vy1    = r_op1.vy;
    assign det_x2     = r_op2.x;
    assign det_y2     = r_op2.y;
    assign det_vx2    = r_op2.vx;
    assign det_vy2    = r_op2.vy;
    assign det_r2     = r_det_r2;

endmodule

// File: tb/tb_coll_pair_sched.sv
// Bench for coll_pair_sched: sweep-level timing model, operand-keyed coll_det
// stub, per-cycle comparison plus directed literal expectations.
module tb_coll_pair_sched;
    localparam int N_OBJ = 8, W = 16, AW = 3, CW = 8, DET_LAT = 10;
    localparam int PER = DET_LAT + 2;
    localparam int NP  = N_OBJ * (N_OBJ - 1) / 2;

    logic clock = 1'b0, rst_n = 1'b1;
    logic wr_en, start, det_trial;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_x, wr_y, wr_vx, wr_vy, r2;
    logic [AW:0]   num_obj;
    logic busy, done, hit_valid, wr_err, det_in_rdy;
    logic [AW-1:0] hit_i, hit_j;
    logic [CW-1:0] hit_count;
    logic [W-1:0]  det_x1, det_y1, det_x2, det_y2, det_vx1, det_vy1, det_vx2, det_vy2, det_r2;

    coll_pair_sched #(.N_OBJ(N_OBJ), .W(W), .AW(AW), .CW(CW), .DET_LAT(DET_LAT)) dut (
        .clock(clock), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_y(wr_y), .wr_vx(wr_vx), .wr_vy(wr_vy), .r2(r2),
        .num_obj(num_obj), .start(start), .busy(busy), .done(done),
        .hit_valid(hit_valid), .hit_i(hit_i), .hit_j(hit_j), .hit_count(hit_count),
        .wr_err(wr_err), .det_x1(det_x1), .det_y1(det_y1), .det_x2(det_x2),
        .det_y2(det_y2), .det_vx1(det_vx1), .det_vy1(det_vy1), .det_vx2(det_vx2),
        .det_vy2(det_vy2), .det_r2(det_r2), .det_in_rdy(det_in_rdy), .det_trial(det_trial)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model state ----------------
    logic [W-1:0] m_x [N_OBJ], m_y [N_OBJ], m_vx [N_OBJ], m_vy [N_OBJ];
    bit   mask [N_OBJ][N_OBJ];
    bit   sw_valid = 0;
    int   sw_c0, sw_np;
    int   sw_pi [NP], sw_pj [NP];
    bit   sw_ph [NP];
    logic [W-1:0] sw_r2;
    int   cyc = 0;
    // probes for literal checks
    int   pr_rdy, pr_done_c = -1, pr_wrerr, pr_x1, pr_vy2, pr_r2, pr_fx1, pr_fx2;
    int   hq [$];

    function automatic bit busy_after(int m);
        return sw_valid && (m - sw_c0) >= 0 && (m - sw_c0) <= sw_np * PER;
    endfunction

    function automatic int exp_hc(int rel);
        int k = rel / PER;
        int s = 0;
        if (k > sw_np) k = sw_np;
        for (int p = 0; p < k; p++) s += int'(sw_ph[p]);
        return s;
    endfunction

    function automatic bit stub_hit(logic [W-1:0] a, logic [W-1:0] b);
        int ia = 0, ib = 0;
        for (int k = N_OBJ - 1; k >= 0; k--) begin
            if (m_x[k] == a) ia = k;
            if (m_x[k] == b) ib = k;
        end
        return mask[ia][ib];
    endfunction

    task automatic latch_sweep();
        int n = (int'(num_obj) > N_OBJ) ? N_OBJ : int'(num_obj);
        sw_np = 0;
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++) begin
                sw_pi[sw_np] = i;
                sw_pj[sw_np] = j;
                sw_ph[sw_np] = mask[i][j];
                sw_np++;
            end
        sw_c0 = cyc; sw_r2 = r2; sw_valid = 1;
        pr_rdy = 0; pr_done_c = -1; pr_wrerr = 0; pr_fx1 = -1; pr_fx2 = -1;
        hq.delete();
    endtask

    task automatic compare_cycle(input bit exp_wr_err);
        int rel, p;
        bit eb, ed, er, eh;
        rel = sw_valid ? cyc - sw_c0 : -1000;
        p   = rel / PER;
        eb  = sw_valid && rel >= 0 && rel <= sw_np * PER;
        ed  = sw_valid && rel == sw_np * PER + 1;
        er  = sw_valid && rel >= 1 && rel < sw_np * PER && (rel % PER) >= 1 && (rel % PER) <= DET_LAT;
        eh  = sw_valid && rel >= PER && rel <= sw_np * PER && (rel % PER) == 0 && sw_ph[p - 1];
        check("busy", busy, eb);
        check("done", done, ed);
        check("det_in_rdy", det_in_rdy, er);
        check("hit_valid", hit_valid, eh);
        check("wr_err", wr_err, exp_wr_err);
        check("hit_count", hit_count, sw_valid ? exp_hc(rel) : 0);
        if (eh) begin
            check("hit_i", hit_i, sw_pi[p - 1]);
            check("hit_j", hit_j, sw_pj[p - 1]);
        end
        if (er) begin
            check("det_x1", det_x1, m_x[sw_pi[p]]);   check("det_y1", det_y1, m_y[sw_pi[p]]);
            check("det_vx1", det_vx1, m_vx[sw_pi[p]]); check("det_vy1", det_vy1, m_vy[sw_pi[p]]);
            check("det_x2", det_x2, m_x[sw_pj[p]]);   check("det_y2", det_y2, m_y[sw_pj[p]]);
            check("det_vx2", det_vx2, m_vx[sw_pj[p]]); check("det_vy2", det_vy2, m_vy[sw_pj[p]]);
            check("det_r2", det_r2, sw_r2);
        end
        if (det_in_rdy) begin
            if (pr_rdy == 0) begin pr_fx1 = int'(det_x1); pr_fx2 = int'(det_x2); end
            pr_rdy++;
            pr_x1 = int'(det_x1); pr_vy2 = int'(det_vy2); pr_r2 = int'(det_r2);
        end
        if (done) pr_done_c = rel + 1;
        if (wr_err) pr_wrerr++;
        if (hit_valid) hq.push_back(int'(hit_i) * 16 + int'(hit_j));
    endtask

    // Single compare process: update model at the edge, check #1 later.
    always @(posedge clock) begin
        bit idle_now, ewe;
        cyc = cyc + 1;
        if (!rst_n) begin
            for (int k = 0; k < N_OBJ; k++) begin m_x[k] = '0; m_y[k] = '0; m_vx[k] = '0; m_vy[k] = '0; end
            sw_valid = 0;
        end else begin
            idle_now = !busy_after(cyc - 1);
            ewe = wr_en && !idle_now;
            if (wr_en && idle_now) begin
                m_x[wr_addr] = wr_x; m_y[wr_addr] = wr_y; m_vx[wr_addr] = wr_vx; m_vy[wr_addr] = wr_vy;
            end
            if (start && idle_now) latch_sweep();
            #1;
            if (rst_n) compare_cycle(ewe);
        end
    end

    // coll_det stub: result appears only after exactly DET_LAT in_rdy cycles.
    logic s_trial;
    int   s_cnt;
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt <= 0; s_trial <= 1'b0;
        end else if (det_in_rdy) begin
            if (s_cnt == DET_LAT - 1) begin
                s_cnt <= 0; s_trial <= stub_hit(det_x1, det_x2);
            end else begin
                if (s_cnt == 0) s_trial <= 1'b0;
                s_cnt <= s_cnt + 1;
            end
        end
    end
    assign det_trial = s_trial;

    // ---------------- stimulus helpers ----------------
    task automatic wr_obj(input int a, input int x, input int y, input int vx, input int vy);
        @(negedge clock);
        wr_en = 1'b1; wr_addr = AW'(a); wr_x = W'(x); wr_y = W'(y); wr_vx = W'(vx); wr_vy = W'(vy);
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic load_std(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) wr_obj(i, 100 + 11 * i, 20 + i, 3 * i + 1, 200 - i);
    endtask

    task automatic go(input int n, input int r);
        @(negedge clock);
        start = 1'b1; num_obj = (AW+1)'(n); r2 = W'(r);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int b = 0;
        while (pr_done_c < 0 && b < budget) begin
            @(posedge clock); #2; b++;
        end
        check("done_seen", pr_done_c >= 0, 1);
    endtask

    task automatic set_mask(input int mode);
        for (int i = 0; i < N_OBJ; i++)
            for (int j = 0; j < N_OBJ; j++)
                mask[i][j] = (mode == 1) ? 1'b1 : 1'b0;
        if (mode == 2) begin mask[0][2] = 1'b1; mask[1][3] = 1'b1; end
        if (mode == 3) mask[6][7] = 1'b1;
    endtask

    function automatic int hq_at(int k);
        return (k < hq.size()) ? hq[k] : -1;
    endfunction

    task automatic zero_check(input string t);
        check({t, "_busy"}, busy, 0);      check({t, "_done"}, done, 0);
        check({t, "_hv"}, hit_valid, 0);   check({t, "_hi"}, hit_i, 0);
        check({t, "_hj"}, hit_j, 0);       check({t, "_hc"}, hit_count, 0);
        check({t, "_werr"}, wr_err, 0);    check({t, "_rdy"}, det_in_rdy, 0);
        check({t, "_ops"}, {det_x1, det_y1, det_x2, det_y2, det_vx1, det_vy1, det_vx2, det_vy2} == '0, 1);
        check({t, "_r2"}, det_r2, 0);
    endtask

    task automatic basic_expect(input string t);
        check({t, "_done_cyc"}, pr_done_c, 74);
        check({t, "_nhits"}, hq.size(), 2);
        check({t, "_hit0"}, hq_at(0), 2);
        check({t, "_hit1"}, hq_at(1), 19);
        check({t, "_count"}, hit_count, 2);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        wr_en = 0; wr_addr = '0; wr_x = '0; wr_y = '0; wr_vx = '0; wr_vy = '0;
        start = 0; num_obj = '0; r2 = '0;
        #2 rst_n = 1'b0;
        #1 zero_check("rst");
        repeat (2) @(negedge clock);
        rst_n = 1'b1;

        // handshake and operands
        set_mask(0);
        wr_obj(0, 1, 2, 3, 4);
        wr_obj(1, 5, 6, 7, 8);
        go(2, 9);
        wait_done(40);
        check("hs_rdy_cycles", pr_rdy, 10);
        check("hs_done_cyc", pr_done_c, 14);
        check("hs_x1", pr_x1, 1);
        check("hs_vy2", pr_vy2, 8);
        check("hs_r2", pr_r2, 9);
        check("hs_count", hit_count, 0);

        // basic sweep
        load_std(0, 3);
        set_mask(2);
        go(4, 50);
        wait_done(200);
        basic_expect("basic");

        // degenerate counts
        go(0, 5);
        wait_done(10);
        check("n0_done_cyc", pr_done_c, 2);
        check("n0_rdy", pr_rdy, 0);
        check("n0_count", hit_count, 0);
        go(1, 5);
        wait_done(10);
        check("n1_done_cyc", pr_done_c, 2);
        check("n1_rdy", pr_rdy, 0);

        // full table, all collide
        load_std(4, 7);
        set_mask(1);
        go(8, 77);
        wait_done(400);
        check("full_done_cyc", pr_done_c, 338);
        check("full_nhits", hq.size(), 28);
        check("full_hit0", hq_at(0), 1);
        check("full_hit7", hq_at(7), 18);
        check("full_hit27", hq_at(27), 103);
        check("full_count", hit_count, 28);

        // num_obj clamp
        set_mask(3);
        go(15, 77);
        wait_done(400);
        check("clamp_done_cyc", pr_done_c, 338);
        check("clamp_nhits", hq.size(), 1);
        check("clamp_hit0", hq_at(0), 103);
        check("clamp_count", hit_count, 1);

        // start and wr_en while busy
        set_mask(2);
        go(4, 50);
        repeat (20) @(negedge clock);
        start = 1'b1; num_obj = (AW+1)'(8);
        wr_en = 1'b1; wr_addr = AW'(2); wr_x = W'(999); wr_y = W'(999); wr_vx = W'(999); wr_vy = W'(999);
        @(negedge clock);
        start = 1'b0; wr_en = 1'b0;
        wait_done(200);
        basic_expect("ign");
        check("ign_wrerr", pr_wrerr, 1);
        go(4, 50);
        wait_done(200);
        basic_expect("ign_next");
        check("ign_next_wrerr", pr_wrerr, 0);

        // reset during RUN of pair (0,3)
        set_mask(1);
        go(4, 50);
        repeat (28) @(posedge clock);
        #3 rst_n = 1'b0;
        #1 zero_check("midrst");
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        load_std(0, 3);
        set_mask(2);
        go(4, 50);
        wait_done(200);
        basic_expect("post");
        check("post_first_x1", pr_fx1, 100);
        check("post_first_x2", pr_fx2, 111);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
